isp_awb_gain_ctrl: RTL

- Closes the auto-white-balance loop: consumes per-frame AWB statistics (valid pixel count, R/G/B sums) and computes white-balance gains for the WB stage.
- Computes R and B gains relative to G with one shared sequential divider, applies optional IIR smoothing, then publishes gains once per accepted frame.
- Sits between the AWB statistics block and the white-balance multiplier, in the pixel clock domain.

---
 rtl/isp_awb_pkg.sv | 19 +
 rtl/isp_awb_div.sv | 79 +++++++
 rtl/isp_awb_gain_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/isp_awb_pkg.sv
// Shared constants and FSM state type for the AWB gain controller.
package isp_awb_pkg;

    localparam int unsigned STAT_BITS_DEF = 32;
    localparam int unsigned GAIN_BITS_DEF = 8;
    localparam int unsigned GAIN_FRAC_DEF = 4;

    localparam int unsigned GAIN_ONE = 1 << GAIN_FRAC_DEF;
    localparam int unsigned GAIN_MAX = (1 << GAIN_BITS_DEF) - 1;
    localparam int unsigned DIV_N    = STAT_BITS_DEF + GAIN_FRAC_DEF;

    typedef enum logic [1:0] {
        IDLE,
        DIV_R,
        DIV_B,
        UPDATE
    } awb_state_t;

endpackage

// File: rtl/isp_awb_div.sv
// Sequential restoring divider, one quotient bit per cycle.
module isp_awb_div
    import isp_awb_pkg::*;
#(
    parameter int unsigned DIVIDEND_BITS = DIV_N,
    parameter int unsigned DIVISOR_BITS  = STAT_BITS_DEF
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic                     busy,
    output logic                     done,
    output logic [DIVIDEND_BITS-1:0] quotient,
    output logic                     div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_BITS - 1);

    logic [DIVISOR_BITS-1:0]  rem_q, dsr_q, src_rem, src_dsr, rem_nx;
    logic [DIVIDEND_BITS-1:0] quo_q, src_quo, quo_nx;
    logic [DIVISOR_BITS:0]    rem_sh;
    logic [CNT_W-1:0]         cnt_q;

    // The start cycle already performs the first iteration on the fresh operands.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dsr = start ? divisor : dsr_q;
        rem_sh  = {src_rem, src_quo[DIVIDEND_BITS-1]};
        if (rem_sh >= {1'b0, src_dsr}) begin
            rem_nx = DIVISOR_BITS'(rem_sh - {1'b0, src_dsr});
            quo_nx = {src_quo[DIVIDEND_BITS-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[DIVISOR_BITS-1:0];
            quo_nx = {src_quo[DIVIDEND_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy  <= 1'b0;
                cnt_q <= '0;
            end else if (start) begin
                rem_q       <= rem_nx;
                quo_q       <= quo_nx;
                dsr_q       <= divisor;
                div_by_zero <= (divisor == '0);
                busy        <= 1'b1;
                cnt_q       <= CNT_W'(1);
            end else if (busy) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                if (cnt_q == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/isp_awb_gain_ctrl.sv
// Auto-white-balance gain controller: per-frame R/B gains relative to G,
// computed with one shared divider and optional IIR smoothing.
module isp_awb_gain_ctrl
    import isp_awb_pkg::*;
#(
    parameter int unsigned STAT_BITS = STAT_BITS_DEF,
    parameter int unsigned GAIN_BITS = GAIN_BITS_DEF,
    parameter int unsigned GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [STAT_BITS-1:0] min_cnt,
    input  logic [2:0]           smooth_shift,
    input  logic                 stat_done,
    input  logic [STAT_BITS-1:0] stat_cnt,
    input  logic [STAT_BITS-1:0] stat_sum_r,
    input  logic [STAT_BITS-1:0] stat_sum_g,
    input  logic [STAT_BITS-1:0] stat_sum_b,
    output logic [GAIN_BITS-1:0] out_gain_r,
    output logic [GAIN_BITS-1:0] out_gain_g,
    output logic [GAIN_BITS-1:0] out_gain_b,
    output logic                 out_valid,
    output logic                 out_busy,
    output logic                 out_drop
);

    localparam int unsigned DIV_BITS = STAT_BITS + GAIN_FRAC;
    localparam logic [GAIN_BITS-1:0] G_ONE = GAIN_BITS'(1 << GAIN_FRAC);
    localparam logic [GAIN_BITS-1:0] G_MAX = '1;

    awb_state_t           state, state_nx;
    logic [STAT_BITS-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [2:0]           shift_q;
    logic [GAIN_BITS-1:0] tgt_r_q;
    logic                 accept, abort;
    logic                 div_start, div_busy, div_done, div_dbz;
    logic [DIV_BITS-1:0]  div_dividend, div_quot;
    logic [STAT_BITS-1:0] div_divisor;

    function automatic logic [GAIN_BITS-1:0] sat_gain(input logic [DIV_BITS-1:0] q,
                                                      input logic dbz);
        logic [GAIN_BITS-1:0] g;
        if (dbz || q > DIV_BITS'(G_MAX)) g = G_MAX;
        else if (q == '0)                g = GAIN_BITS'(1);
        else                             g = q[GAIN_BITS-1:0];
        return g;
    endfunction

    // Forced +/-1 step keeps the gain converging once the shifted difference rounds to zero.
    function automatic logic [GAIN_BITS-1:0] smooth_gain(input logic [GAIN_BITS-1:0] old,
                                                         input logic [GAIN_BITS-1:0] tgt,
                                                         input logic [2:0]           sh);
        logic signed [GAIN_BITS:0]   diff, step;
        logic signed [GAIN_BITS+1:0] sum;
        logic [GAIN_BITS-1:0]        g;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, old});
        step = diff >>> sh;
        if (sh != 3'd0 && step == '0 && diff != '0)
            step = diff[GAIN_BITS] ? '1 : (GAIN_BITS+1)'(1);
        sum = $signed({2'b00, old}) + $signed({step[GAIN_BITS], step});
        if (sum[GAIN_BITS+1] || sum == '0) g = GAIN_BITS'(1);
        else if (sum[GAIN_BITS])           g = G_MAX;
        else                               g = sum[GAIN_BITS-1:0];
        return g;
    endfunction

    assign accept = (state == IDLE) && stat_done && enable && (stat_cnt >= min_cnt);
    assign abort  = (state != IDLE) && !enable;

    // The R divide starts on the first DIV_R cycle; its done cycle launches the B divide.
    assign div_start    = (state == DIV_R) && !div_busy;
    assign div_dividend = DIV_BITS'(sum_g_q) << GAIN_FRAC;
    assign div_divisor  = div_done ? sum_b_q : sum_r_q;

    isp_awb_div #(
        .DIVIDEND_BITS (DIV_BITS),
        .DIVISOR_BITS  (STAT_BITS)
    ) u_div (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .start       (div_start),
        .abort       (abort),
        .dividend    (div_dividend),
        .divisor     (div_divisor),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quot),
        .div_by_zero (div_dbz)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)   state_nx = DIV_R;
            DIV_R:   if (div_done) state_nx = DIV_B;
            DIV_B:   if (div_done) state_nx = UPDATE;
            UPDATE:                state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_q    <= '0;
            sum_g_q    <= '0;
            sum_b_q    <= '0;
            shift_q    <= '0;
            tgt_r_q    <= G_ONE;
            out_gain_r <= G_ONE;
            out_gain_b <= G_ONE;
            out_valid  <= 1'b0;
            out_drop   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_drop  <= stat_done && (state != IDLE);
            if (accept) begin
                sum_r_q <= stat_sum_r;
                sum_g_q <= stat_sum_g;
                sum_b_q <= stat_sum_b;
                shift_q <= smooth_shift;
            end
            if (state == DIV_R && div_done)
                tgt_r_q <= sat_gain(div_quot, div_dbz);
            // The divider still holds the B result while in UPDATE.
            if (state == UPDATE && enable) begin
                out_gain_r <= smooth_gain(out_gain_r, tgt_r_q, shift_q);
                out_gain_b <= smooth_gain(out_gain_b, sat_gain(div_quot, div_dbz), shift_q);
                out_valid  <= 1'b1;
            end
        end
    end

    assign out_gain_g = G_ONE;
    assign out_busy   = (state != IDLE);

endmodule
